// File: rtl/async_input_conditioner.sv
// Multi-channel conditioner for asynchronous inputs: synchroniser chain, glitch
// filter, registered rise/fall pulses and a saturating rise counter per channel.
module async_input_conditioner #(
    parameter int WIDTH         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       din,
    input  logic                   clr,
    output logic [WIDTH-1:0]       dout,
    output logic [WIDTH-1:0]       rise,
    output logic [WIDTH-1:0]       fall,
    output logic [WIDTH*CNT_W-1:0] event_cnt,
    output logic [WIDTH-1:0]       ovf
);

    localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [FW-1:0]    FLT_MAX = FW'(FILTER_CYCLES - 1);
    localparam logic [FW-1:0]    FLT_ONE = FW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_sr_q, sync_sr_d;
        logic [FW-1:0]          flt_cnt_q, flt_cnt_d;
        logic                   dout_q, dout_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   ovf_q, ovf_d;
        logic                   sync_lvl;

        assign sync_lvl = sync_sr_q[SYNC_STAGES-1];

        // Synchroniser shift and level filter; a new level is taken only after
        // it has disagreed with dout for FILTER_CYCLES consecutive edges.
        always_comb begin
            sync_sr_d = {sync_sr_q[SYNC_STAGES-2:0], din[i]};
            flt_cnt_d = flt_cnt_q;
            dout_d    = dout_q;
            rise_d    = 1'b0;
            fall_d    = 1'b0;
            if (sync_lvl == dout_q) begin
                flt_cnt_d = {FW{1'b0}};
            end else if (flt_cnt_q == FLT_MAX) begin
                dout_d    = sync_lvl;
                flt_cnt_d = {FW{1'b0}};
                rise_d    = sync_lvl;
                fall_d    = ~sync_lvl;
            end else begin
                flt_cnt_d = flt_cnt_q + FLT_ONE;
            end
        end

        // Saturating rise counter; clr wins over a coincident rise.
        always_comb begin
            cnt_d = cnt_q;
            ovf_d = ovf_q;
            if (clr) begin
                cnt_d = {CNT_W{1'b0}};
                ovf_d = 1'b0;
            end else if (rise_d) begin
                if (cnt_q == CNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                cnt_d = cnt_q;
            end
        end

        // Channel state registers with asynchronous clear.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_sr_q <= {SYNC_STAGES{1'b0}};
                flt_cnt_q <= {FW{1'b0}};
                dout_q    <= 1'b0;
                rise_q    <= 1'b0;
                fall_q    <= 1'b0;
                cnt_q     <= {CNT_W{1'b0}};
                ovf_q     <= 1'b0;
            end else begin
                sync_sr_q <= sync_sr_d;
                flt_cnt_q <= flt_cnt_d;
                dout_q    <= dout_d;
                rise_q    <= rise_d;
                fall_q    <= fall_d;
                cnt_q     <= cnt_d;
                ovf_q     <= ovf_d;
            end
        end

        assign dout[i]                     = dout_q;
        assign rise[i]                     = rise_q;
        assign fall[i]                     = fall_q;
        assign ovf[i]                      = ovf_q;
        assign event_cnt[i*CNT_W +: CNT_W] = cnt_q;
    end

endmodule

// File: tb/tb_async_input_conditioner.sv
// Scoreboard bench: three instances (defaults, CNT_W=2, SYNC_STAGES=3/FILTER_CYCLES=1).
module tb_async_input_conditioner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  din_a, din_b, din_c;
    logic        clr_a, clr_b, clr_c;
    logic [3:0]  dout_a, rise_a, fall_a, ovf_a;
    logic [3:0]  dout_b, rise_b, fall_b, ovf_b;
    logic [3:0]  dout_c, rise_c, fall_c, ovf_c;
    logic [31:0] cnt_a, cnt_c;
    logic [7:0]  cnt_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
        string       tag;
    } exp_t;
    exp_t sb[$];

    localparam int S_DOUT_A = 0, S_RISE_A = 1, S_FALL_A = 2, S_CNT_A = 3, S_OVF_A = 4;
    localparam int S_CNT_B  = 5, S_OVF_B  = 6;
    localparam int S_DOUT_C = 7, S_RISE_C = 8, S_FALL_C = 9, S_CNT_C = 10;

    always #5 clk = ~clk;

    async_input_conditioner u_dut_a (
        .clk(clk), .rst_n(rst_n), .din(din_a), .clr(clr_a),
        .dout(dout_a), .rise(rise_a), .fall(fall_a), .event_cnt(cnt_a), .ovf(ovf_a)
    );

    async_input_conditioner #(.CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .clr(clr_b),
        .dout(dout_b), .rise(rise_b), .fall(fall_b), .event_cnt(cnt_b), .ovf(ovf_b)
    );

    async_input_conditioner #(.SYNC_STAGES(3), .FILTER_CYCLES(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .din(din_c), .clr(clr_c),
        .dout(dout_c), .rise(rise_c), .fall(fall_c), .event_cnt(cnt_c), .ovf(ovf_c)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_DOUT_A: obs = {28'd0, dout_a};
            S_RISE_A: obs = {28'd0, rise_a};
            S_FALL_A: obs = {28'd0, fall_a};
            S_CNT_A:  obs = cnt_a;
            S_OVF_A:  obs = {28'd0, ovf_a};
            S_CNT_B:  obs = {24'd0, cnt_b};
            S_OVF_B:  obs = {28'd0, ovf_b};
            S_DOUT_C: obs = {28'd0, dout_c};
            S_RISE_C: obs = {28'd0, rise_c};
            S_FALL_C: obs = {28'd0, fall_c};
            S_CNT_C:  obs = cnt_c;
            default:  obs = 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push(input int due, input int sel, input logic [31:0] exp, input string tag);
        exp_t e;
        e.due = due; e.sel = sel; e.exp = exp; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_due();
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check_val(sb[i].tag, obs(sb[i].sel), sb[i].exp);
                sb.delete(i);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        check_due();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int c;
        rst_n = 1'b0;
        din_a = 4'h0; din_b = 4'h0; din_c = 4'h0;
        clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
        run(2);
        check_val("por_dout_a", {28'd0, dout_a}, 32'h0);
        check_val("por_rise_a", {28'd0, rise_a}, 32'h0);
        check_val("por_fall_a", {28'd0, fall_a}, 32'h0);
        check_val("por_cnt_a", cnt_a, 32'h0);
        check_val("por_ovf_a", {28'd0, ovf_a}, 32'h0);
        check_val("por_cnt_b", {24'd0, cnt_b}, 32'h0);
        check_val("por_dout_c", {28'd0, dout_c}, 32'h0);
        rst_n = 1'b1;

        // all channels rise together
        din_a = 4'hF; c = cyc;
        push(c + 5, S_DOUT_A, 32'h0, "allrise_dout_e5");
        push(c + 5, S_CNT_A, 32'h0, "allrise_cnt_e5");
        push(c + 6, S_DOUT_A, 32'hF, "allrise_dout_e6");
        push(c + 6, S_RISE_A, 32'hF, "allrise_rise_e6");
        push(c + 6, S_CNT_A, 32'h0101_0101, "allrise_cnt_e6");
        push(c + 7, S_RISE_A, 32'h0, "allrise_rise_e7");
        run(8);

        // asynchronous reset mid-cycle, din held high
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_dout_a", {28'd0, dout_a}, 32'h0);
        check_val("arst_cnt_a", cnt_a, 32'h0);
        tick();
        rst_n = 1'b1; c = cyc;
        push(c + 5, S_DOUT_A, 32'h0, "rel_dout_e5");
        push(c + 6, S_DOUT_A, 32'hF, "rel_dout_e6");
        push(c + 6, S_RISE_A, 32'hF, "rel_rise_e6");
        push(c + 6, S_CNT_A, 32'h0101_0101, "rel_cnt_e6");
        run(8);

        din_a = 4'h0; c = cyc;
        push(c + 5, S_DOUT_A, 32'hF, "allfall_dout_e5");
        push(c + 6, S_DOUT_A, 32'h0, "allfall_dout_e6");
        push(c + 6, S_FALL_A, 32'hF, "allfall_fall_e6");
        push(c + 7, S_FALL_A, 32'h0, "allfall_fall_e7");
        push(c + 7, S_CNT_A, 32'h0101_0101, "allfall_cnt_e7");
        run(8);

        clr_a = 1'b1; tick(); clr_a = 1'b0;
        check_val("clr_cnt_a", cnt_a, 32'h0);

        // clean transitions on channel 0
        din_a = 4'h1; c = cyc;
        push(c + 5, S_DOUT_A, 32'h0, "ch0_dout_e5");
        push(c + 6, S_DOUT_A, 32'h1, "ch0_dout_e6");
        push(c + 6, S_RISE_A, 32'h1, "ch0_rise_e6");
        push(c + 7, S_RISE_A, 32'h0, "ch0_rise_e7");
        push(c + 6, S_CNT_A, 32'h1, "ch0_cnt_e6");
        run(8);
        din_a = 4'h0; c = cyc;
        push(c + 6, S_DOUT_A, 32'h0, "ch0f_dout_e6");
        push(c + 6, S_FALL_A, 32'h1, "ch0f_fall_e6");
        push(c + 7, S_FALL_A, 32'h0, "ch0f_fall_e7");
        push(c + 7, S_CNT_A, 32'h1, "ch0f_cnt_e7");
        run(8);

        // 3-cycle glitch on channel 1 is rejected
        din_a = 4'h2; c = cyc;
        for (int k = 1; k <= 9; k++) begin
            push(c + k, S_DOUT_A, 32'h0, "glitch_dout");
            push(c + k, S_RISE_A, 32'h0, "glitch_rise");
            push(c + k, S_FALL_A, 32'h0, "glitch_fall");
        end
        push(c + 9, S_CNT_A, 32'h1, "glitch_cnt");
        run(3); din_a = 4'h0; run(8);

        // 4-cycle pulse on channel 1 is accepted
        din_a = 4'h2; c = cyc;
        push(c + 5, S_DOUT_A, 32'h0, "p4_dout_e5");
        push(c + 6, S_DOUT_A, 32'h2, "p4_dout_e6");
        push(c + 6, S_RISE_A, 32'h2, "p4_rise_e6");
        push(c + 6, S_CNT_A, 32'h0000_0101, "p4_cnt_e6");
        push(c + 9, S_DOUT_A, 32'h2, "p4_dout_e9");
        push(c + 10, S_DOUT_A, 32'h0, "p4_dout_e10");
        push(c + 10, S_FALL_A, 32'h2, "p4_fall_e10");
        run(4); din_a = 4'h0; run(8);

        // clr coincident with a rise on channel 3
        din_a = 4'h8; c = cyc;
        push(c + 5, S_CNT_A, 32'h0000_0101, "clrp_cnt_e5");
        push(c + 6, S_CNT_A, 32'h0, "clrp_cnt_e6");
        push(c + 6, S_OVF_A, 32'h0, "clrp_ovf_e6");
        push(c + 6, S_RISE_A, 32'h8, "clrp_rise_e6");
        push(c + 6, S_DOUT_A, 32'h8, "clrp_dout_e6");
        push(c + 7, S_CNT_A, 32'h0, "clrp_cnt_e7");
        run(5); clr_a = 1'b1; run(1); clr_a = 1'b0; run(2);
        din_a = 4'h0; run(8);

        // reset pulse while the filter count sits at 2 discards the transition
        din_a = 4'h1; c = cyc;
        for (int k = 5; k <= 12; k++) begin
            push(c + k, S_DOUT_A, 32'h0, "rstflt_dout");
            push(c + k, S_RISE_A, 32'h0, "rstflt_rise");
        end
        push(c + 12, S_CNT_A, 32'h0, "rstflt_cnt");
        run(4);
        din_a = 4'h0;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        run(9);

        // saturation with CNT_W=2 on channel 2
        for (int k = 1; k <= 5; k++) begin
            din_b = 4'h4; c = cyc;
            if (k == 4) push(c + 5, S_OVF_B, 32'h0, "sat_ovf_pre4");
            push(c + 6, S_CNT_B, ((k < 3) ? k : 3) << 4, $sformatf("sat_cnt_r%0d", k));
            push(c + 6, S_OVF_B, (k >= 4) ? 32'h4 : 32'h0, $sformatf("sat_ovf_r%0d", k));
            run(8); din_b = 4'h0; run(8);
        end
        clr_b = 1'b1; tick(); clr_b = 1'b0;
        check_val("sat_clr_cnt", {24'd0, cnt_b}, 32'h0);
        check_val("sat_clr_ovf", {28'd0, ovf_b}, 32'h0);

        // SYNC_STAGES=3, FILTER_CYCLES=1: step latency 4, then per-cycle toggles
        din_c = 4'h1; c = cyc;
        push(c + 3, S_DOUT_C, 32'h0, "f1_dout_e3");
        push(c + 4, S_DOUT_C, 32'h1, "f1_dout_e4");
        push(c + 4, S_RISE_C, 32'h1, "f1_rise_e4");
        run(6);
        c = cyc;
        for (int k = 0; k < 4; k++) begin
            push(c + 4 + k, S_DOUT_C, (k % 2 == 0) ? 32'h0 : 32'h1, $sformatf("tog_dout_%0d", k));
            push(c + 4 + k, S_RISE_C, (k % 2 == 0) ? 32'h0 : 32'h1, $sformatf("tog_rise_%0d", k));
            push(c + 4 + k, S_FALL_C, (k % 2 == 0) ? 32'h1 : 32'h0, $sformatf("tog_fall_%0d", k));
        end
        push(c + 8, S_RISE_C, 32'h0, "tog_rise_end");
        push(c + 8, S_FALL_C, 32'h0, "tog_fall_end");
        push(c + 8, S_CNT_C, 32'h3, "tog_cnt_end");
        din_c = 4'h0; tick();
        din_c = 4'h1; tick();
        din_c = 4'h0; tick();
        din_c = 4'h1; run(7);

        check_val("sb_empty", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/async_input_conditioner.md
# async_input_conditioner

Parametrised, single-clock conditioner for asynchronous inputs, with WIDTH independent channels. Each channel has a configurable-depth synchroniser, a glitch filter, rise/fall edge pulses and a saturating rise-event counter. It terminates external or foreign-domain signals at the clk boundary of a benchmark design, giving the timing flow a multi-stage synchroniser chain and a filter and counter datapath behind it.

## Interface
Parameters:
- WIDTH, 4, number of independent channels (≥1)
- SYNC_STAGES, 2, synchroniser flops per channel (≥2)
- FILTER_CYCLES, 4, consecutive cycles a new synchronised level must persist before it is accepted (≥1)
- CNT_W, 8, width of each channel's rise-event counter (≥1)

Ports:
- clk  in  1  sole clock; all state is updated on posedge
- rst_n  in  1  asynchronous, active-low reset
- din  in  WIDTH  asynchronous inputs, one bit per channel
- clr  in  1  synchronous clear of all event counters and ovf flags
- dout  out  WIDTH  filtered, synchronised level per channel
- rise  out  WIDTH  one-cycle pulse when a channel's dout goes 0→1
- fall  out  WIDTH  one-cycle pulse when a channel's dout goes 1→0
- event_cnt  out  WIDTH*CNT_W  rise counts; channel i occupies bits [i*CNT_W +: CNT_W]
- ovf  out  WIDTH  sticky flag: a rise arrived while that channel's counter was saturated

## Operation
Each channel behaves identically and independently.

- **Synchroniser:** shift register of SYNC_STAGES flops. Stage 0 samples din[i]. The last stage, sync_q, is the only value used downstream. No logic sits between the stages.
- **Filter:** a stability counter flt_cnt counts from 0 to FILTER_CYCLES-1, with width clog2(FILTER_CYCLES), minimum 1. On each edge:
  - If sync_q == dout: flt_cnt <= 0.
  - If sync_q != dout and flt_cnt == FILTER_CYCLES-1: dout <= sync_q, flt_cnt <= 0, and rise or fall is asserted for that cycle.
  - Otherwise: flt_cnt <= flt_cnt + 1.
- **Glitch rejection:** a level at sync_q lasting fewer than FILTER_CYCLES cycles produces no dout change and no pulse.
- **Edge pulses:** rise and fall are registered. Each is high for exactly the one cycle following the edge at which dout changed. rise and fall are never both high on the same channel.
- **Event counter:** on a rise, event_cnt <= event_cnt + 1.
  - The counter saturates at 2^CNT_W − 1.
  - A rise while the counter is saturated leaves the count unchanged and sets ovf.
  - ovf stays set until clr or reset.
- **clr:** when asserted, all channels get event_cnt <= 0 and ovf <= 0 on that edge.
  - clr has priority over a coincident rise: the count becomes 0 and that rise is not counted.
  - clr does not affect the synchroniser, filter, dout, rise or fall.
- **Reset:** asserting rst_n low immediately forces every flop to 0, regardless of clk. This covers sync stages, flt_cnt, dout, rise, fall, event_cnt and ovf.
  - A transition that is in the filter when reset hits is discarded.
  - After release, a din held at 1 is accepted as a normal rise, with full latency and a count of 1.

## Timing
- Reset value of every output is 0: dout, rise, fall, event_cnt and ovf.
- Latency for a clean din transition is SYNC_STAGES + FILTER_CYCLES edges, counting the first edge that samples the new value as edge 1. dout, rise/fall and the event_cnt increment all become visible after that edge. With default parameters this is edge 6.
- Minimum accepted pulse width at sync_q is FILTER_CYCLES cycles.
- The maximum edge-pulse rate per channel is one per FILTER_CYCLES cycles; with FILTER_CYCLES=1, one per cycle.
- FILTER_CYCLES=1 degenerates to a plain synchroniser plus one output register.
- All outputs are registered, and no combinational path runs from any input to any output.
- Channels do not interact, except through the shared clr.

## Test plan
- **Reset values:** assert rst_n=0 mid-cycle with din=4'hF → all outputs read 0 immediately. Release rst_n and hold din=4'hF → after edge 6, dout=4'hF and rise=4'hF for one cycle, then every channel's event_cnt=1.
- **Clean transitions (defaults):** din[0] goes 0→1 → dout[0]=1 and rise[0]=1 after edge 6 only, and event_cnt[7:0]=1. Then din[0] goes 1→0 → fall[0]=1 for one cycle after 6 edges, and the count stays at 1.
- **Glitch rejection:** din[1] high for 3 cycles, then low → dout[1] stays 0, with no rise or fall pulse and count 0. The same stimulus held for 4 cycles is accepted.
- **Saturation:** with CNT_W=2, apply 5 clean rises on channel 2 → after the 3rd rise the count is 3 with ovf[2]=0. After the 4th rise the count is 3 with ovf[2]=1. After the 5th, both are unchanged.
- **clr priority:** assert clr on the same edge a rise pulse is generated → event_cnt=0 and ovf=0, rise still pulses, and dout=1.
- **Reset mid-filter, and FILTER_CYCLES=1:** with defaults, pulse rst_n low when flt_cnt=2 → no dout change. With SYNC_STAGES=3 and FILTER_CYCLES=1, a din step gives dout at edge 4, and 1-cycle-apart sync_q toggles produce alternating rise/fall on consecutive cycles.
